// File: rtl/bcd_pkg.sv
// Shared types and seven-segment encoding for the BCD scan display.
// seg bit order is g..a, active-high.
package bcd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Returns {valid, seg}; codes 10..15 are invalid and blank.
    function automatic logic [7:0] seg_lookup(input logic [3:0] nibble);
        case (nibble)
            4'd0:    seg_lookup = {1'b1, SEG_0};
            4'd1:    seg_lookup = {1'b1, SEG_1};
            4'd2:    seg_lookup = {1'b1, SEG_2};
            4'd3:    seg_lookup = {1'b1, SEG_3};
            4'd4:    seg_lookup = {1'b1, SEG_4};
            4'd5:    seg_lookup = {1'b1, SEG_5};
            4'd6:    seg_lookup = {1'b1, SEG_6};
            4'd7:    seg_lookup = {1'b1, SEG_7};
            4'd8:    seg_lookup = {1'b1, SEG_8};
            4'd9:    seg_lookup = {1'b1, SEG_9};
            default: seg_lookup = {1'b0, SEG_BLANK};
        endcase
    endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// Data and display signals between the BCD counter chain and the scan driver.
// master drives the digit word and controls; slave drives the display outputs.
interface bcd_scan_display_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] digits_in;
    logic                load;
    logic                blank_lz;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                scan_done;
    logic                err;

    modport master (
        output digits_in, load, blank_lz,
        input  seg, an, scan_done, err
    );

    modport slave (
        input  digits_in, load, blank_lz,
        output seg, an, scan_done, err
    );
endinterface

// File: rtl/bcd_seg_decode.sv
// Combinational BCD nibble to seven-segment decoder with a validity flag.
module bcd_seg_decode
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg,
    output logic       valid
);

    assign {valid, seg} = seg_lookup(digit);

endmodule

// File: rtl/bcd_scan_display.sv
// Captures a BCD word, holds it for whole frames and time-multiplexes it onto
// a common-segment 7-segment display with leading-zero blanking.
module bcd_scan_display
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4
) (
    input  logic               clk,
    input  logic               rst,
    bcd_scan_display_if.slave  bus
);

    localparam int IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    state_t                  state;
    logic [DIGITS-1:0][3:0]  din;
    logic [DIGITS-1:0][3:0]  pend;
    logic [DIGITS-1:0][3:0]  disp;
    logic                    pend_v;
    logic [IW-1:0]           idx;
    logic [PW-1:0]           pre;

    logic [6:0]              seg_q;
    logic [DIGITS-1:0]       an_q;
    logic                    done_q;
    logic                    err_q;

    logic [3:0]              cur_digit;
    logic [6:0]              dec_seg;
    logic                    dec_valid;
    logic [DIGITS-1:0]       lz_mask;
    logic                    lz_run;
    logic                    load_bad;
    logic                    digit_end;
    logic                    frame_end;

    assign din       = bus.digits_in;
    assign cur_digit = disp[idx];
    assign digit_end = (pre == PRE_LAST);
    assign frame_end = digit_end && (idx == IDX_LAST);

    bcd_seg_decode u_dec (
        .digit (cur_digit),
        .seg   (dec_seg),
        .valid (dec_valid)
    );

    // A digit is blanked when it and every more-significant digit are zero.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        lz_run  = 1'b1;
        lz_mask = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lz_run     = lz_run && (disp[k] == 4'd0);
            lz_mask[k] = bus.blank_lz && lz_run && (k != 0);
        end
    end

    always_comb begin
        load_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (din[k] > 4'd9) load_bad = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; outputs below are registered from the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are reset too, so a reset mid-frame drops
            // both the displayed and the pending word.
            state  <= IDLE;
            pend   <= '0;
            disp   <= '0;
            pend_v <= 1'b0;
            idx    <= '0;
            pre    <= '0;
            seg_q  <= SEG_BLANK;
            an_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (bus.load && load_bad) err_q <= 1'b1;

            case (state)
                IDLE: begin
                    seg_q  <= SEG_BLANK;
                    an_q   <= '0;
                    done_q <= 1'b0;
                    if (bus.load) begin
                        disp  <= din;
                        idx   <= '0;
                        pre   <= '0;
                        state <= SCAN;
                    end
                end

                SCAN: begin
                    seg_q  <= (dec_valid && !lz_mask[idx]) ? dec_seg : SEG_BLANK;
                    an_q   <= DIGITS'(1) << idx;
                    done_q <= frame_end;

                    if (digit_end) pre <= '0;
                    else           pre <= pre + 1'b1;

                    if (frame_end) begin
                        // New data only swaps in here, so a frame never mixes words.
                        idx <= '0;
                        if (bus.load) begin
                            disp   <= din;
                            pend_v <= 1'b0;
                        end else if (pend_v) begin
                            disp   <= pend;
                            pend_v <= 1'b0;
                        end
                    end else begin
                        if (digit_end) idx <= idx + 1'b1;
                        if (bus.load) begin
                            pend   <= din;
                            pend_v <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.scan_done = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: frame-position reference model
// compared every cycle, plus literal frame expectations for directed scenarios.
module tb_bcd_scan_display;

    localparam int D     = 4;
    localparam int P     = 4;
    localparam int FRAME = D * P;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_scan_display_if #(.DIGITS(D)) bus();

    bcd_scan_display #(.DIGITS(D), .PRESCALE(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Digit d of word w as it should appear, including leading-zero blanking.
    function automatic logic [6:0] shown(input logic [15:0] w, input int d, input logic lz);
        logic [3:0] nib;
        nib = w[4*d +: 4];
        if (lz && d != 0 && (w >> (4*d)) == 16'd0) return 7'h00;
        return seg_of(nib);
    endfunction

    function automatic logic any_bad(input logic [15:0] w);
        for (int k = 0; k < D; k++) begin
            if (w[4*k +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference model: a linear position within the frame, the word on show,
    // and the newest word waiting for the next frame.
    bit          m_on = 1'b0;
    bit          m_scan;
    int          m_pos;
    int          m_d;
    logic [15:0] m_show;
    logic [15:0] m_pend;
    bit          m_pend_v;
    bit          m_err;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_done;
    logic        e_err;

    always @(posedge clk) begin
        if (rst) begin
            m_on     = 1'b1;
            m_scan   = 1'b0;
            m_pos    = 0;
            m_pend_v = 1'b0;
            m_err    = 1'b0;
            m_show   = '0;
            e_seg    = '0;
            e_an     = '0;
            e_done   = 1'b0;
        end else if (m_on) begin
            if (!m_scan) begin
                e_seg  = '0;
                e_an   = '0;
                e_done = 1'b0;
                if (bus.load) begin
                    m_scan = 1'b1;
                    m_pos  = 0;
                    m_show = bus.digits_in;
                end
            end else begin
                m_d    = m_pos / P;
                e_an   = 4'(1 << m_d);
                e_seg  = shown(m_show, m_d, bus.blank_lz);
                e_done = (m_pos == FRAME - 1);
                if (m_pos == FRAME - 1) begin
                    m_pos = 0;
                    if (bus.load) begin
                        m_show   = bus.digits_in;
                        m_pend_v = 1'b0;
                    end else if (m_pend_v) begin
                        m_show   = m_pend;
                        m_pend_v = 1'b0;
                    end
                end else begin
                    m_pos++;
                    if (bus.load) begin
                        m_pend   = bus.digits_in;
                        m_pend_v = 1'b1;
                    end
                end
            end
            if (bus.load && any_bad(bus.digits_in)) m_err = 1'b1;
        end
        e_err = m_err;
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("model_seg",  32'(bus.seg),       32'(e_seg));
            check("model_an",   32'(bus.an),        32'(e_an));
            check("model_done", 32'(bus.scan_done), 32'(e_done));
            check("model_err",  32'(bus.err),       32'(e_err));
        end
    end

    // Caller sits on a negedge in IDLE; returns on the next negedge.
    task automatic load_word(input logic [15:0] w);
        bus.digits_in = w;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load      = 1'b0;
    endtask

    // Checks one full output frame; segs holds digit k at [7k +: 7].
    task automatic frame_check(input logic [27:0] segs);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            check("frame_an",   32'(bus.an),        32'(1 << (k / P)));
            check("frame_seg",  32'(bus.seg),       32'(segs[7*(k/P) +: 7]));
            check("frame_done", 32'(bus.scan_done), 32'(k == FRAME - 1));
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [15:0] rnd_w;
    int          r;

    initial begin
        bus.digits_in = '0;
        bus.load      = 1'b0;
        bus.blank_lz  = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset with no load.
        repeat (6) @(negedge clk);
        check("idle_an",   32'(bus.an),        32'h0);
        check("idle_seg",  32'(bus.seg),       32'h0);
        check("idle_done", 32'(bus.scan_done), 32'h0);
        check("idle_err",  32'(bus.err),       32'h0);

        // First load, then a frame with two mid-frame loads; only the later one shows.
        load_word(16'h1234);
        frame_check({7'h06, 7'h5B, 7'h4F, 7'h66});
        for (int q = 0; q < FRAME; q++) begin
            bus.load      = (q == 5 || q == 9);
            bus.digits_in = (q == 5) ? 16'h9876 : (q == 9) ? 16'h0005 : 16'($urandom);
            @(negedge clk);
        end
        bus.load = 1'b0;
        frame_check({7'h3F, 7'h3F, 7'h3F, 7'h6D});

        // Leading-zero blanking on, then off.
        pulse_reset();
        bus.blank_lz = 1'b1;
        load_word(16'h0050);
        frame_check({7'h00, 7'h00, 7'h6D, 7'h3F});
        bus.blank_lz = 1'b0;
        frame_check({7'h3F, 7'h3F, 7'h6D, 7'h3F});

        // Invalid code: sticky err, blanked digit.
        pulse_reset();
        check("err_after_rst", 32'(bus.err), 32'h0);
        load_word(16'h12A4);
        check("err_set", 32'(bus.err), 32'h1);
        frame_check({7'h06, 7'h5B, 7'h00, 7'h66});
        bus.digits_in = 16'h1234;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (8) @(negedge clk);
        check("err_sticky", 32'(bus.err), 32'h1);
        check("digit2_an",  32'(bus.an),  32'h4);

        // Reset during digit 2 together with load: everything clears, load ignored.
        rst           = 1'b1;
        bus.load      = 1'b1;
        bus.digits_in = 16'h5555;
        @(negedge clk);
        check("rst_seg",  32'(bus.seg),       32'h0);
        check("rst_an",   32'(bus.an),        32'h0);
        check("rst_done", 32'(bus.scan_done), 32'h0);
        check("rst_err",  32'(bus.err),       32'h0);
        rst      = 1'b0;
        bus.load = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_stays_idle", 32'(bus.an), 32'h0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            bus.load = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < D; k++) begin
                r = $urandom_range(0, 15);
                if (r < 4)       rnd_w[4*k +: 4] = 4'd0;
                else if (r < 15) rnd_w[4*k +: 4] = 4'($urandom_range(0, 9));
                else             rnd_w[4*k +: 4] = 4'($urandom_range(10, 15));
            end
            bus.digits_in = rnd_w;
            if ($urandom_range(0, 49) == 0) bus.blank_lz = ~bus.blank_lz;
            @(negedge clk);
        end
        rst      = 1'b0;
        bus.load = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
